// File: rtl/nibble_serial_adder.sv
// Multi-precision add/subtract sequencer. One 4-bit carry-lookahead adder is reused
// once per nibble, LSB first, and the carry is held in a register between nibbles.
module carry_look_ahead_adder_4bits (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);
  logic [3:0] w_p, w_g;
  logic [4:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;
  // Each carry is expanded from the nibble carry-in rather than rippled
  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);
  assign o_s = w_p ^ w_c[3:0];
  assign o_c = w_c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;

  logic [NIB-1:0][3:0] r_opa, r_opb, r_sum;
  logic [CW-1:0]       r_cnt;
  logic                r_carry, r_cout, r_ovf;
  logic [3:0]          w_s, w_na, w_nb;
  logic                w_c;

  assign w_na = r_opa[r_cnt];
  assign w_nb = r_opb[r_cnt];

  carry_look_ahead_adder_4bits u_cla (
    .i_a(w_na), .i_b(w_nb), .i_c(r_carry), .o_s(w_s), .o_c(w_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)       w_next = RUN;
      RUN:     if (r_cnt == LAST)  w_next = DONE;
      DONE:    if (out_ready)      w_next = IDLE;
      default:                     w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_opa   <= a;
          r_opb   <= sub ? ~b : b;
          r_carry <= sub | c_in;
          r_cnt   <= '0;
        end
        RUN: begin
          r_sum[r_cnt] <= w_s;
          r_carry      <= w_c;
          r_cnt        <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_cout <= w_c;
            // Same-sign operands producing an opposite-sign result
            r_ovf  <= ~(r_opa[NIB-1][3] ^ r_opb[NIB-1][3]) & (r_opa[NIB-1][3] ^ w_s[3]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = r_sum;
  assign c_out     = r_cout;
  assign overflow  = r_ovf;
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-precision add/subtract sequencer built around one instance of carry_look_ahead_adder_4bits. It accepts WIDTH-bit operands over a valid/ready handshake and feeds the 4-bit CLA one nibble per cycle, LSB first. The carry is chained between nibbles through a register. It returns the WIDTH-bit result with carry-out and signed overflow over a second valid/ready handshake.

Parameters:
WIDTH, 16, operand/result width in bits; multiple of 4, ≥4. NIB = WIDTH/4 (derived, not overridable).

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry-in for add; ignored when sub=1
sub  input  1  0: A+B+c_in; 1: A-B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
c_out  output  1  carry out of bit WIDTH-1; in subtract mode 1 means no borrow
overflow  output  1  signed two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, nibble counter=0, carry reg=0, operand regs=0. Outputs: in_ready=1, out_valid=0, sum=0, c_out=0, overflow=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture a into opA and b into opB. If sub=1, capture ~b instead.
  - Carry reg loads c_in when sub=0, or 1 when sub=1.
  - Counter clears to 0 and the state moves to RUN.
- RUN:
  - in_ready=0.
  - The CLA inputs are opA[4k+3:4k], opB[4k+3:4k] and the carry reg, where k is the counter.
  - Each edge writes the CLA sum into sum[4k+3:4k], loads the CLA c_out into the carry reg, and increments k.
  - On the edge where k=NIB-1, latch c_out from the CLA and compute overflow = opA[W-1] XNOR opB[W-1] AND (opA[W-1] XOR final sum bit W-1). Then go to DONE.
- DONE:
  - out_valid=1.
  - sum, c_out and overflow are held stable until handshake.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
- Latency: out_valid rises exactly NIB clock edges after the acceptance edge (4 cycles for WIDTH=16). Minimum issue interval is NIB+2 cycles. No back-to-back overlap: in_ready=0 throughout RUN and DONE.
- Outputs: sum bits not yet written in RUN keep their previous value. Consumers use them only when out_valid=1.
- in_valid while busy is ignored. Operand inputs may change freely after the acceptance edge.
- out_ready while not in DONE is ignored.
- Reset mid-operation (RUN or DONE): the transaction is abandoned with no output, and all outputs take their reset values immediately.
- Arithmetic is modulo 2^WIDTH. c_out is the true carry out of the MSB nibble.
- Operand and result registers are WIDTH bits wide. The counter is clog2(NIB) bits wide, minimum 1.

Test Plan:
- WIDTH=16, sub=0, c_in=0, a=0x1234, b=0x4321 -> out_valid 4 edges after accept; sum=0x5555, c_out=0, overflow=0.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, overflow=0 (carry ripples through all 4 nibbles). Also a=0xFFFF, b=0xFFFF, c_in=1 -> sum=0xFFFF, c_out=1.
- a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, overflow=1. Also a=0x8000, b=0x8000 -> sum=0x0000, c_out=1, overflow=1.
- sub=1, c_in=1, a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0, overflow=0; c_in has no effect. Also sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> sum/c_out/overflow stable, in_ready=0, and in_valid pulses ignored. Then out_ready=1 -> IDLE, and the next accept produces a correct independent result.
- Assert rst_n=0 asynchronously mid-RUN (after 2 nibbles) -> outputs go to reset values without waiting for a clock edge. After release, a new transaction 0x0001+0x0001 gives sum=0x0002.
